// File: rtl/sobol_stream_if.sv
// Command, configuration and output-beat bundle for sobol_stream.
// master drives commands/config and accepts beats; slave is the generator.
interface sobol_stream_if #(
  parameter int WIDTH = 32,
  parameter int M     = 50,
  parameter int LANES = 2
);
  localparam int AW = $clog2(M * WIDTH);
  localparam int DW = $clog2(M);

  logic                   cfg_we;
  logic                   cfg_sel;
  logic [AW-1:0]          cfg_addr;
  logic [WIDTH-1:0]       cfg_wdata;
  logic                   valid_in;
  logic                   ready_out;
  logic [WIDTH-1:0]       cmd_start;
  logic [WIDTH-1:0]       cmd_count;
  logic                   valid_out;
  logic                   ready_in;
  logic [LANES*WIDTH-1:0] sobol_out;
  logic [WIDTH-1:0]       idx_out;
  logic [DW-1:0]          dim_out;
  logic                   last_dim;
  logic                   last_path;
  logic                   busy;
  logic                   err_range;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata, valid_in, cmd_start, cmd_count, ready_in,
    input  ready_out, valid_out, sobol_out, idx_out, dim_out, last_dim, last_path, busy, err_range
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, valid_in, cmd_start, cmd_count, ready_in,
    output ready_out, valid_out, sobol_out, idx_out, dim_out, last_dim, last_path, busy, err_range
  );
endinterface

// File: rtl/sobol_stream.sv
// Multi-lane Sobol point generator: Gray-code seeded INIT, then Antonov-Saleev
// recursion x ^= v[d][c] with per-dimension digital shift on the output.
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 32;
endpackage

// One lane owns dimensions d with d % LANES == lane: their direction bank,
// state words and shift words. Slot s of a lane is dimension s*LANES+lane.
module sobol_lane #(
  parameter int WIDTH = 32,
  parameter int G     = 2,
  parameter int GW    = 1,
  parameter int BW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir_we,
  input  logic [BW-1:0]    dir_waddr,
  input  logic [WIDTH-1:0] dir_wdata,
  input  logic             sh_we,
  input  logic [GW-1:0]    sh_slot,
  input  logic [WIDTH-1:0] sh_wdata,
  input  logic             rd_en,
  input  logic [BW-1:0]    rd_addr,
  input  logic             upd_en,
  input  logic [GW-1:0]    upd_slot,
  input  logic             clr,
  input  logic [GW-1:0]    out_slot,
  output logic [WIDTH-1:0] out_val
);
  localparam int STAGES = 1;

  logic [WIDTH-1:0]         mem [G*WIDTH];
  logic [WIDTH-1:0]         rdata_q;
  logic [G-1:0][WIDTH-1:0]  x_q, x_d, sh_q, sh_d;
  logic [STAGES:1]          vld_pipe_q;
  logic [STAGES:0]          vld_pipe;
  logic [GW-1:0]            slot_q, slot_d;

  always_ff @(posedge clk) begin
    if (dir_we) mem[dir_waddr] <= dir_wdata;
    if (rd_en)  rdata_q <= mem[rd_addr];
  end

  always_comb begin
    vld_pipe = {vld_pipe_q, upd_en};
    slot_d   = upd_slot;
    x_d      = x_q;
    sh_d     = sh_q;
    // Read data lands one cycle after issue; fold it into the slot it was read for.
    if (clr)                   x_d = '0;
    else if (vld_pipe[STAGES]) x_d[slot_q] = x_q[slot_q] ^ rdata_q;
    if (sh_we) sh_d[sh_slot] = sh_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      sh_q       <= '0;
      vld_pipe_q <= '0;
      slot_q     <= '0;
    end else begin
      x_q        <= x_d;
      sh_q       <= sh_d;
      vld_pipe_q <= vld_pipe[STAGES-1:0];
      slot_q     <= slot_d;
    end
  end

  assign out_val = x_q[out_slot] ^ sh_q[out_slot];
endmodule

module sobol_stream #(
  parameter int WIDTH = fpga_cfg_pkg::FP_WIDTH,
  parameter int M     = 50,
  parameter int LANES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sobol_stream_if.slave  bus
);
  localparam int G  = M / LANES;
  localparam int KW = $clog2(WIDTH);
  localparam int GW = $clog2(G);
  localparam int BW = GW + KW;
  localparam int AW = $clog2(M * WIDTH);
  localparam int DW = $clog2(M);
  localparam int MW = M * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAIN, S_RUN} state_e;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0] data;
    logic [WIDTH-1:0]            idx;
    logic [DW-1:0]               dim;
    logic                        last_dim;
    logic                        last_path;
  } beat_t;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  start_q, start_d, last_idx_q, last_idx_d, n_q, n_d;
  logic [GW-1:0]     g_q, g_d;
  logic              done_q, done_d, err_q, err_d, valid_q, valid_d;
  beat_t             beat_q, beat_d;

  logic [LANES-1:0]             dir_we, sh_we, rd_en, upd_en;
  logic [LANES-1:0][BW-1:0]     rd_addr;
  logic [LANES-1:0][GW-1:0]     upd_slot;
  logic [LANES-1:0][WIDTH-1:0]  lane_val;
  logic [GW-1:0]                wslot;
  logic [BW-1:0]                waddr;
  logic                         clr;
  logic [WIDTH:0]               sum;
  logic                         range_bad;
  logic [WIDTH-1:0]             gray;
  logic [KW-1:0]                c_idx;

  assign sum       = {1'b0, bus.cmd_start} + {1'b0, bus.cmd_count};
  assign range_bad = sum[WIDTH] && (sum[WIDTH-1:0] != '0);
  assign gray      = start_q ^ (start_q >> 1);

  // Lowest zero bit of n selects the direction word for the n -> n+1 step.
  always_comb begin
    c_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (!n_q[i]) c_idx = KW'(i);
  end

  always_comb begin
    int cd;
    cd     = 0;
    dir_we = '0;
    sh_we  = '0;
    if (!bus.cfg_sel) cd = int'(bus.cfg_addr[AW-1:KW]);
    else              cd = int'(bus.cfg_addr);
    if (bus.cfg_we && state_q == S_IDLE && cd < M) begin
      for (int l = 0; l < LANES; l++) begin
        if (cd % LANES == l) begin
          dir_we[l] = !bus.cfg_sel;
          sh_we[l]  = bus.cfg_sel;
        end
      end
    end
    wslot = GW'(cd / LANES);
    waddr = {wslot, bus.cfg_addr[KW-1:0]};
  end

  always_comb begin
    int id;
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    last_idx_d = last_idx_q;
    n_d        = n_q;
    g_d        = g_q;
    done_d     = done_q;
    err_d      = err_q;
    valid_d    = valid_q;
    beat_d     = beat_q;
    clr        = 1'b0;
    rd_en      = '0;
    upd_en     = '0;
    rd_addr    = '0;
    upd_slot   = '0;
    id         = int'(cnt_q[AW-1:KW]);
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in && bus.cmd_count != '0) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            clr        = 1'b1;
            start_d    = bus.cmd_start;
            last_idx_d = bus.cmd_start + bus.cmd_count - 1'b1;
            n_d        = bus.cmd_start;
            g_d        = '0;
            cnt_d      = '0;
            done_d     = 1'b0;
            state_d    = S_INIT;
          end
        end
      end
      S_INIT: begin
        // Every word is read; the gray bit only gates the XOR, so INIT length is fixed.
        for (int l = 0; l < LANES; l++) begin
          if (id % LANES == l) begin
            rd_en[l]    = 1'b1;
            upd_en[l]   = gray[cnt_q[KW-1:0]];
            rd_addr[l]  = {GW'(id / LANES), cnt_q[KW-1:0]};
            upd_slot[l] = GW'(id / LANES);
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(MW - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN: begin
        if (valid_q && bus.ready_in) begin
          valid_d = 1'b0;
          if (beat_q.last_path && beat_q.last_dim) state_d = S_IDLE;
        end
        if (!done_q && (!valid_q || bus.ready_in)) begin
          valid_d          = 1'b1;
          beat_d.data      = lane_val;
          beat_d.idx       = n_q;
          beat_d.dim       = DW'(int'(g_q) * LANES);
          beat_d.last_dim  = (g_q == GW'(G - 1));
          beat_d.last_path = (n_q == last_idx_q);
          rd_en            = '1;
          // n = all-ones is always the final point, and has no successor.
          upd_en           = {LANES{~&n_q}};
          for (int l = 0; l < LANES; l++) begin
            rd_addr[l]  = {g_q, c_idx};
            upd_slot[l] = g_q;
          end
          if (g_q == GW'(G - 1)) begin
            g_d = '0;
            n_d = n_q + 1'b1;
            if (n_q == last_idx_q) done_d = 1'b1;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      start_q    <= '0;
      last_idx_q <= '0;
      n_q        <= '0;
      g_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      last_idx_q <= last_idx_d;
      n_q        <= n_d;
      g_q        <= g_d;
      done_q     <= done_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
    end
  end

  sobol_lane #(.WIDTH(WIDTH), .G(G), .GW(GW), .BW(BW)) u_lane [LANES-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir_we    (dir_we),
    .dir_waddr (waddr),
    .dir_wdata (bus.cfg_wdata),
    .sh_we     (sh_we),
    .sh_slot   (wslot),
    .sh_wdata  (bus.cfg_wdata),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .upd_en    (upd_en),
    .upd_slot  (upd_slot),
    .clr       (clr),
    .out_slot  (g_q),
    .out_val   (lane_val)
  );

  assign bus.ready_out = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err_range = err_q;
  assign bus.valid_out = valid_q;
  assign bus.sobol_out = beat_q.data;
  assign bus.idx_out   = beat_q.idx;
  assign bus.dim_out   = beat_q.dim;
  assign bus.last_dim  = beat_q.last_dim;
  assign bus.last_path = beat_q.last_path;
endmodule

// File: tb/tb_sobol_stream.sv
// Directed bench for sobol_stream: WIDTH=32, M=4, LANES=2, v[d][k]=1<<(31-k),
// expected points from direct Gray-code evaluation (bit-reversed gray(n)).
module tb_sobol_stream;
  localparam int WIDTH = 32;
  localparam int M     = 4;
  localparam int LANES = 2;
  localparam int G     = M / LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobol_stream_if #(.WIDTH(WIDTH), .M(M), .LANES(LANES)) bus ();
  sobol_stream #(.WIDTH(WIDTH), .M(M), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vecs = 0;
  int errs = 0;
  logic [31:0] shv [M];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] n);
    logic [31:0] g;
    logic [31:0] r;
    g = n ^ (n >> 1);
    for (int i = 0; i < 32; i++) r[31-i] = g[i];
    return r;
  endfunction

  task automatic send_cmd(input logic [31:0] s, input logic [31:0] c);
    bus.valid_in  = 1'b1;
    bus.cmd_start = s;
    bus.cmd_count = c;
    @(negedge clk);
    bus.valid_in  = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge; lat_exp=0 skips the latency check.
  task automatic collect(input logic [31:0] start, input int count, input bit rnd, input int lat_exp);
    int nb, b, cyc, g;
    bit stalled, first;
    logic [31:0] n;
    logic [LANES*WIDTH-1:0] s_dat;
    logic [31:0] s_idx;
    logic [1:0]  s_dim;
    logic        s_ld, s_lp;
    nb = count * G; b = 0; cyc = 0; stalled = 0; first = 1;
    s_dat = '0; s_idx = '0; s_dim = '0; s_ld = 0; s_lp = 0;
    while (b < nb && cyc < 400 + 8 * nb) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("hold_valid", bus.valid_out, 1);
        chk("hold_data", bus.sobol_out, s_dat);
        chk("hold_idx", bus.idx_out, s_idx);
        chk("hold_flags", {bus.dim_out, bus.last_dim, bus.last_path}, {s_dim, s_ld, s_lp});
      end
      bus.ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.valid_out) begin
        if (first && lat_exp > 0) chk("latency", cyc, lat_exp);
        first = 0;
        if (bus.ready_in) begin
          n = start + 32'(b / G);
          g = b % G;
          for (int l = 0; l < LANES; l++)
            chk($sformatf("b%0d_lane%0d", b, l), bus.sobol_out[l*WIDTH +: WIDTH], model(n) ^ shv[g*LANES+l]);
          chk($sformatf("b%0d_idx", b), bus.idx_out, n);
          chk($sformatf("b%0d_dim", b), bus.dim_out, g * LANES);
          chk($sformatf("b%0d_last_dim", b), bus.last_dim, g == G - 1);
          chk($sformatf("b%0d_last_path", b), bus.last_path, b >= nb - G);
          b++;
          stalled = 0;
        end else begin
          stalled = 1;
          s_dat = bus.sobol_out; s_idx = bus.idx_out; s_dim = bus.dim_out;
          s_ld = bus.last_dim; s_lp = bus.last_path;
        end
      end
    end
    if (b < nb) chk("timeout_beats", b, nb);
    bus.ready_in = 1'b1;
    @(negedge clk);
    chk("busy_after_run", bus.busy, 0);
    chk("valid_after_run", bus.valid_out, 0);
  endtask

  initial begin
    int seen;
    bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.valid_in = 0; bus.cmd_start = '0; bus.cmd_count = '0; bus.ready_in = 1;
    for (int i = 0; i < M; i++) shv[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_valid", bus.valid_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_err", bus.err_range, 0);
    chk("rst_data", bus.sobol_out, 0);
    chk("rst_idx", {bus.idx_out, bus.dim_out, bus.last_dim, bus.last_path}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < M; d++) begin
      for (int k = 0; k < WIDTH; k++) begin
        bus.cfg_we = 1; bus.cfg_sel = 0;
        bus.cfg_addr = 7'(d * WIDTH + k);
        bus.cfg_wdata = 32'h8000_0000 >> k;
        @(negedge clk);
      end
    end
    bus.cfg_we = 0;

    // start=0, count=4: 8 beats, latency M*WIDTH+2
    send_cmd(32'd0, 32'd4);
    chk("acc_busy", bus.busy, 1);
    chk("acc_ready", bus.ready_out, 0);
    collect(32'd0, 4, 0, M * WIDTH + 2);

    send_cmd(32'd2, 32'd1);
    collect(32'd2, 1, 0, 0);

    // shift[1]=all ones; writes issued while busy must not land
    bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_addr = 7'd1; bus.cfg_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.cfg_we = 0;
    shv[1] = 32'hFFFF_FFFF;
    send_cmd(32'd1, 32'd1);
    bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_addr = 7'd0; bus.cfg_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.cfg_sel = 0; bus.cfg_addr = 7'd0; bus.cfg_wdata = 32'h0;
    @(negedge clk);
    bus.cfg_we = 0;
    collect(32'd1, 1, 0, 0);

    bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_addr = 7'd1; bus.cfg_wdata = 32'h0;
    @(negedge clk);
    bus.cfg_we = 0;
    shv[1] = 32'h0;

    // 16 paths with a random ready pattern
    send_cmd(32'd0, 32'd16);
    collect(32'd0, 16, 1, 0);

    send_cmd(32'd5, 32'd0);
    chk("cnt0_busy", bus.busy, 0);
    chk("cnt0_err", bus.err_range, 0);

    // start+count = 2^32+1 is rejected
    send_cmd(32'hFFFF_FFFF, 32'd2);
    chk("rej_err", bus.err_range, 1);
    chk("rej_busy", bus.busy, 0);
    seen = 0;
    repeat (M * WIDTH + 10) begin
      @(negedge clk);
      if (bus.valid_out) seen++;
    end
    chk("rej_no_valid", seen, 0);
    send_cmd(32'hFFFF_FFFF, 32'd1);
    chk("edge_err_clr", bus.err_range, 0);
    chk("edge_busy", bus.busy, 1);
    collect(32'hFFFF_FFFF, 1, 0, 0);

    // reset mid-run, then reissue
    send_cmd(32'd0, 32'd4);
    repeat (M * WIDTH + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.sobol_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd(32'd0, 32'd4);
    collect(32'd0, 4, 0, M * WIDTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
